// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: one bit per clock, LSB first, with registered result/borrow.
// Optional modular correction (add Q when a < b) enabled by defining SERIAL_SUB_MOD_CORRECT_EN.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int Q     = 12289
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be in 2..32");
    end
    if (longint'(Q) >= (longint'(1) << WIDTH)) begin : g_bad_q
        $error("serial_subtractor: Q must be below 2**WIDTH");
    end

`ifdef SERIAL_SUB_MOD_CORRECT_EN
    typedef enum logic [1:0] {IDLE, SUB, CORR, DONE} state_t;
    localparam logic [WIDTH-1:0] Q_VAL = WIDTH'(Q);
`else
    typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;
`endif

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic             br;
    logic             d_bit;
    logic             br_next;
    logic             last_bit;

    assign d_bit    = a_sh[0] ^ b_sh[0] ^ br;
    assign br_next  = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign last_bit = (cnt == LAST_BIT);

`ifdef SERIAL_SUB_MOD_CORRECT_EN
    // During CORR, a_sh is reused to stream Q into the serial adder.
    logic cy;
    logic s_bit;
    logic cy_next;

    assign s_bit   = r_sh[0] ^ a_sh[0] ^ cy;
    assign cy_next = (r_sh[0] & a_sh[0]) | (cy & (r_sh[0] ^ a_sh[0]));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            r_sh   <= '0;
            br     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef SERIAL_SUB_MOD_CORRECT_EN
            cy     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SUB;
                    end
                end
                SUB: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    r_sh <= {d_bit, r_sh[WIDTH-1:1]};
                    br   <= br_next;
                    if (last_bit) begin
                        cnt <= '0;
`ifdef SERIAL_SUB_MOD_CORRECT_EN
                        if (br_next) begin
                            a_sh  <= Q_VAL;
                            cy    <= 1'b0;
                            state <= CORR;
                        end else begin
                            state <= DONE;
                        end
`else
                        state <= DONE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef SERIAL_SUB_MOD_CORRECT_EN
                CORR: begin
                    a_sh <= a_sh >> 1;
                    r_sh <= {s_bit, r_sh[WIDTH-1:1]};
                    cy   <= cy_next;
                    if (last_bit) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                DONE: begin
                    diff   <= r_sh;
                    borrow <= br;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
